// File: rtl/ram_bus_ctl.sv
// ram_bus_ctl: req/ack bus front end for the 32Kx16 main RAM.
// Ports: clk/reset, bus_* master side, ram_* registered RAM side.
module ram_bus_ctl #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] RAM_LIMIT   = 16'o160000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_wr,
  input  logic        bus_byte,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_err,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_di,
  output logic        ram_ce_n,
  output logic        ram_we_n,
  output logic        ram_byte_op,
  input  logic [15:0] ram_do
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t      st, st_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [15:0] addr_nx, di_nx, rdata_nx;
  logic        ce_nx, we_nx, byte_nx;
  logic        ack_nx, err_nx;
  logic        hit, odd;

  assign hit = bus_req && (bus_addr < RAM_LIMIT);
  assign odd = !bus_byte && bus_addr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      cnt         <= 3'd0;
      ram_addr    <= 16'd0;
      ram_di      <= 16'd0;
      ram_ce_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_byte_op <= 1'b0;
      bus_rdata   <= 16'd0;
      bus_ack     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      st          <= st_nx;
      cnt         <= cnt_nx;
      ram_addr    <= addr_nx;
      ram_di      <= di_nx;
      ram_ce_n    <= ce_nx;
      ram_we_n    <= we_nx;
      ram_byte_op <= byte_nx;
      bus_rdata   <= rdata_nx;
      bus_ack     <= ack_nx;
      bus_err     <= err_nx;
    end
  end

  // Every RAM-facing signal is computed here and registered
  // above, so the strobes never glitch.
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    addr_nx  = ram_addr;
    di_nx    = ram_di;
    ce_nx    = ram_ce_n;
    we_nx    = ram_we_n;
    byte_nx  = ram_byte_op;
    rdata_nx = bus_rdata;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    unique case (st)
      IDLE: begin
        unique case (1'b1)
          (hit && odd): begin
            err_nx = 1'b1;
            st_nx  = DONE;
          end
          (hit && !odd): begin
            addr_nx = bus_addr;
            di_nx   = bus_wdata;
            byte_nx = bus_byte;
            ce_nx   = 1'b0;
            if (bus_wr) begin
              we_nx = 1'b0;
              st_nx = WRITE;
            end else begin
              cnt_nx = 3'(WAIT_CYCLES);
              st_nx  = READ;
            end
          end
          default: ;
        endcase
      end
      WRITE: begin
        ce_nx  = 1'b1;
        we_nx  = 1'b1;
        ack_nx = 1'b1;
        st_nx  = DONE;
      end
      READ: begin
        if (cnt == 3'd0) begin
          rdata_nx = ram_do;
          ack_nx   = 1'b1;
          ce_nx    = 1'b1;
          st_nx    = DONE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      DONE: begin
        // Held requests park here so they are never re-serviced.
        if (!bus_req) st_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_bus_ctl.sv
// tb_ram_bus_ctl: directed bench for ram_bus_ctl.
// Vector table plus hand sequences for reset and held requests.
module tb_ram_bus_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req;
  logic        bus_wr;
  logic        bus_byte;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic [15:0] ram_addr;
  logic [15:0] ram_di;
  logic        ram_ce_n;
  logic        ram_we_n;
  logic        ram_byte_op;
  logic [15:0] ram_do;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_bus_ctl #(
    .WAIT_CYCLES(1),
    .RAM_LIMIT(16'o160000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_req(bus_req),
    .bus_wr(bus_wr),
    .bus_byte(bus_byte),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .bus_err(bus_err),
    .ram_addr(ram_addr),
    .ram_di(ram_di),
    .ram_ce_n(ram_ce_n),
    .ram_we_n(ram_we_n),
    .ram_byte_op(ram_byte_op),
    .ram_do(ram_do)
  );

  // RAM model: no reset, writes on the rising edge.
  logic [15:0] mem [0:32767];
  logic [15:0] rw;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) begin
      if (!ram_byte_op)
        mem[ram_addr[15:1]] <= ram_di;
      else if (ram_addr[0])
        mem[ram_addr[15:1]][15:8] <= ram_di[7:0];
      else
        mem[ram_addr[15:1]][7:0] <= ram_di[7:0];
    end
  end

  assign rw = mem[ram_addr[15:1]];
  assign ram_do = !ram_byte_op ? rw :
                  {8'h00, ram_addr[0] ? rw[15:8] : rw[7:0]};

  // Activity monitor, sampled mid-cycle.
  int ce_cyc = 0, we_cyc = 0, ack_cyc = 0;
  int err_cyc = 0, acc = 0;
  logic prev_ce = 1'b1;

  always @(negedge clk) begin
    if (!ram_ce_n) ce_cyc++;
    if (!ram_we_n) we_cyc++;
    if (bus_ack) ack_cyc++;
    if (bus_err) err_cyc++;
    if (prev_ce && !ram_ce_n) acc++;
    prev_ce = ram_ce_n;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ce_n"}, 32'(ram_ce_n), 32'd1);
    chk({tag, " we_n"}, 32'(ram_we_n), 32'd1);
    chk({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, " ram_di"}, 32'(ram_di), 32'd0);
    chk({tag, " byte_op"}, 32'(ram_byte_op), 32'd0);
    chk({tag, " rdata"}, 32'(bus_rdata), 32'd0);
    chk({tag, " ack"}, 32'(bus_ack), 32'd0);
    chk({tag, " err"}, 32'(bus_err), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic        byt;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          resp;   // 0 none, 1 ack, 2 err
    int          lat;
    logic [15:0] rdata;
    int          ce;
    int          we;
  } vec_t;

  vec_t vt[$];

  task automatic run(input vec_t v, input int idx);
    int ce0, we0, ak0, er0;
    int kind, lat;
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    ce0 = ce_cyc; we0 = we_cyc; ak0 = ack_cyc; er0 = err_cyc;
    bus_wr = v.wr; bus_byte = v.byt;
    bus_addr = v.addr; bus_wdata = v.wdata;
    bus_req = 1'b1;
    kind = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1 && v.resp != 0) begin
        bus_wr = ~v.wr; bus_byte = ~v.byt;
        bus_addr = v.addr ^ 16'h0F0E;
        bus_wdata = ~v.wdata;
      end
      if (bus_ack) begin kind = 1; lat = i; break; end
      if (bus_err) begin kind = 2; lat = i; break; end
    end
    @(negedge clk);
    bus_req = 1'b0;
    repeat (3) @(negedge clk);
    chk({s, " resp"}, 32'(kind), 32'(v.resp));
    chk({s, " lat"}, 32'(lat), 32'(v.lat));
    chk({s, " rdata"}, 32'(bus_rdata), 32'(v.rdata));
    chk({s, " ce_cyc"}, 32'(ce_cyc - ce0), 32'(v.ce));
    chk({s, " we_cyc"}, 32'(we_cyc - we0), 32'(v.we));
    chk({s, " ack_cyc"}, 32'(ack_cyc - ak0),
        32'(v.resp == 1 ? 1 : 0));
    chk({s, " err_cyc"}, 32'(err_cyc - er0),
        32'(v.resp == 2 ? 1 : 0));
    if (v.resp == 1) begin
      chk({s, " ram_addr"}, 32'(ram_addr), 32'(v.addr));
      chk({s, " byte_op"}, 32'(ram_byte_op), 32'(v.byt));
      chk({s, " ram_di"}, 32'(ram_di), 32'(v.wdata));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, k0, hit;
    reset = 1'b1; bus_req = 1'b0; bus_wr = 1'b0;
    bus_byte = 1'b0; bus_addr = 16'd0; bus_wdata = 16'd0;

    // wr byt addr wdata resp lat rdata ce we
    vt.push_back('{1'b1, 1'b0, 16'o000500, 16'o012706, 1, 2, 16'h0000, 1, 1});
    vt.push_back('{1'b0, 1'b0, 16'o000500, 16'h0000, 1, 3, 16'o012706, 2, 0});
    vt.push_back('{1'b1, 1'b1, 16'o000501, 16'hAAFF, 1, 2, 16'o012706, 1, 1});
    vt.push_back('{1'b0, 1'b1, 16'o000501, 16'h0000, 1, 3, 16'o000377, 2, 0});
    vt.push_back('{1'b0, 1'b1, 16'o000500, 16'h0000, 1, 3, 16'o000306, 2, 0});
    vt.push_back('{1'b0, 1'b0, 16'o000500, 16'h0000, 1, 3, 16'hFFC6, 2, 0});
    vt.push_back('{1'b0, 1'b0, 16'o000503, 16'h0000, 2, 1, 16'hFFC6, 0, 0});
    vt.push_back('{1'b1, 1'b0, 16'o000503, 16'h5555, 2, 1, 16'hFFC6, 0, 0});
    vt.push_back('{1'b1, 1'b0, 16'o000502, 16'h3456, 1, 2, 16'hFFC6, 1, 1});
    vt.push_back('{1'b1, 1'b1, 16'o000503, 16'hEE12, 1, 2, 16'hFFC6, 1, 1});
    vt.push_back('{1'b0, 1'b0, 16'o000502, 16'h0000, 1, 3, 16'h1256, 2, 0});
    vt.push_back('{1'b0, 1'b0, 16'o177560, 16'h0000, 0, 0, 16'h1256, 0, 0});
    vt.push_back('{1'b0, 1'b0, 16'o160000, 16'h0000, 0, 0, 16'h1256, 0, 0});
    vt.push_back('{1'b1, 1'b0, 16'o157776, 16'o052525, 1, 2, 16'h1256, 1, 1});
    vt.push_back('{1'b0, 1'b0, 16'o157776, 16'h0000, 1, 3, 16'o052525, 2, 0});
    vt.push_back('{1'b0, 1'b1, 16'o157777, 16'h0000, 1, 3, 16'h0055, 2, 0});

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) run(vt[i], i);

    chk("mem 0500", 32'(mem[16'o000500 >> 1]), 32'hFFC6);
    chk("mem 0502", 32'(mem[16'o000502 >> 1]), 32'h1256);
    chk("mem 157776", 32'(mem[16'o157776 >> 1]), 32'(16'o052525));

    // Request held for 10 cycles after ack: one access only.
    @(negedge clk);
    a0 = acc; k0 = ack_cyc; hit = 0;
    bus_wr = 1'b0; bus_byte = 1'b0; bus_addr = 16'o000502;
    bus_req = 1'b1;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      @(posedge clk); #1;
      if (bus_ack) hit = 1;
    end
    repeat (10) @(negedge clk);
    bus_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold acked", 32'(hit), 32'd1);
    chk("hold accesses", 32'(acc - a0), 32'd1);
    chk("hold acks", 32'(ack_cyc - k0), 32'd1);

    // Early drop of bus_req while reading: still acked once.
    @(negedge clk);
    k0 = ack_cyc; hit = 0;
    bus_addr = 16'o000500; bus_req = 1'b1;
    @(negedge clk);
    bus_req = 1'b0;
    for (int i = 0; i < 10 && hit == 0; i++) begin
      @(posedge clk); #1;
      if (bus_ack) hit = 1;
    end
    repeat (3) @(negedge clk);
    chk("drop acked", 32'(hit), 32'd1);
    chk("drop acks", 32'(ack_cyc - k0), 32'd1);
    chk("drop rdata", 32'(bus_rdata), 32'hFFC6);

    // Reset during the READ wait cycle.
    @(negedge clk);
    k0 = ack_cyc;
    bus_wr = 1'b0; bus_byte = 1'b0; bus_addr = 16'o000500;
    bus_req = 1'b1;
    @(negedge clk);
    chk("rdwait ce_n", 32'(ram_ce_n), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("rd reset");
    @(negedge clk);
    reset = 1'b0; bus_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rd reset acks", 32'(ack_cyc - k0), 32'd0);

    // Reset during WRITE: the RAM write still lands.
    @(negedge clk);
    k0 = ack_cyc;
    bus_wr = 1'b1; bus_addr = 16'o000600; bus_wdata = 16'o070707;
    bus_req = 1'b1;
    @(negedge clk);
    chk("wr we_n", 32'(ram_we_n), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("wr reset");
    @(negedge clk);
    reset = 1'b0; bus_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("wr reset acks", 32'(ack_cyc - k0), 32'd0);
    chk("wr reset mem", 32'(mem[16'o000600 >> 1]), 32'(16'o070707));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
